// File: rtl/udma_rx_ch_arbiter.sv
// Per-channel elastic FIFO with synchronous flush and occupancy count.
// Latency: 1 cycle write-to-read; head is visible combinationally once written.
// Backpressure: writer must gate on !full; reader pops only when !empty.
module udma_rx_ch_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   lvl
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
            if (rd_rdy) rd_ptr <= rd_ptr + 1'b1;
            if (wr_vld && !rd_rdy)
                cnt <= cnt + 1'b1;
            else if (!wr_vld && rd_rdy)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld && !clr) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
    assign empty  = (cnt == '0);
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign lvl    = cnt;
endmodule

// N-channel RX concentrator: per-channel FIFO, round-robin with optional packet lock, tagged output.
// Latency: 2 cycles input handshake to out_valid_o; sustains 1 beat/cycle.
// Backpressure: out_* held stable while !out_ready_i; in_ready_o drops when a FIFO is full or cleared.
module udma_rx_ch_arbiter #(
    parameter  int N_CH       = 4,
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 4,
    parameter  int LOCK_PKT   = 1,
    localparam int ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_CH-1:0]         in_valid_i,
    input  logic [N_CH*DATA_W-1:0]  in_data_i,
    input  logic [N_CH*2-1:0]       in_datasize_i,
    input  logic [N_CH-1:0]         in_sot_i,
    input  logic [N_CH-1:0]         in_eot_i,
    output logic [N_CH-1:0]         in_ready_o,
    input  logic [N_CH-1:0]         clr_i,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [1:0]              out_datasize_o,
    output logic [ID_W-1:0]         out_ch_o,
    output logic                    out_sot_o,
    output logic                    out_eot_o,
    input  logic                    out_ready_i,
    output logic [N_CH*LVL_W-1:0]   lvl_o
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        size;
        logic              sot;
        logic              eot;
    } ent_t;

    ent_t             wr_ent [N_CH];
    ent_t             head   [N_CH];
    logic [LVL_W-1:0] lvl    [N_CH];
    logic [N_CH-1:0]  empty;
    logic [N_CH-1:0]  full;
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  pop;
    logic [N_CH-1:0]  elig;

    logic             can_load;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_ch;
    logic [ID_W:0]    idx;
    ent_t             gnt_ent;
    logic [ID_W-1:0]  rr_ptr;
    logic             lock_vld;
    logic [ID_W-1:0]  lock_ch;

    function automatic logic [ID_W-1:0] nxt_ch(input logic [ID_W-1:0] c);
        return (c == ID_W'(N_CH-1)) ? '0 : c + 1'b1;
    endfunction

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign in_ready_o[i] = !full[i] && !clr_i[i];
        assign push[i]       = in_valid_i[i] && in_ready_o[i];
        assign wr_ent[i]     = {in_data_i[i*DATA_W +: DATA_W], in_datasize_i[2*i +: 2],
                                in_sot_i[i], in_eot_i[i]};
        assign pop[i]        = grant_vld && (grant_ch == ID_W'(i));
        // A locked channel excludes everyone else, even while it has nothing to send
        assign elig[i]       = !empty[i] && !clr_i[i] && (!lock_vld || (lock_ch == ID_W'(i)));
        assign lvl_o[i*LVL_W +: LVL_W] = lvl[i];

        udma_rx_ch_fifo #(
            .DW    ($bits(ent_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk_i),
            .rst    (rst_i),
            .clr    (clr_i[i]),
            .wr_vld (push[i]),
            .wr_dat (wr_ent[i]),
            .rd_rdy (pop[i]),
            .rd_dat (head[i]),
            .empty  (empty[i]),
            .full   (full[i]),
            .lvl    (lvl[i])
        );
    end

    assign can_load = !out_valid_o || out_ready_i;

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        for (int off = 0; off < N_CH; off++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(off);
            if (idx >= (ID_W+1)'(N_CH)) idx = idx - (ID_W+1)'(N_CH);
            if (!grant_vld && elig[idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_ch  = idx[ID_W-1:0];
            end
        end
        if (!can_load) grant_vld = 1'b0;
    end

    assign gnt_ent = head[grant_ch];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o    <= 1'b0;
            out_data_o     <= '0;
            out_datasize_o <= '0;
            out_ch_o       <= '0;
            out_sot_o      <= 1'b0;
            out_eot_o      <= 1'b0;
            rr_ptr         <= '0;
            lock_vld       <= 1'b0;
            lock_ch        <= '0;
        end else begin
            if (can_load) begin
                out_valid_o <= grant_vld;
                if (grant_vld) begin
                    out_data_o     <= gnt_ent.data;
                    out_datasize_o <= gnt_ent.size;
                    out_ch_o       <= grant_ch;
                    out_sot_o      <= gnt_ent.sot;
                    out_eot_o      <= gnt_ent.eot;
                    rr_ptr         <= nxt_ch(grant_ch);
                end
            end
            if (grant_vld && (LOCK_PKT != 0)) begin
                if (lock_vld) begin
                    if (gnt_ent.eot) lock_vld <= 1'b0;
                end else if (gnt_ent.sot && !gnt_ent.eot) begin
                    lock_vld <= 1'b1;
                    lock_ch  <= grant_ch;
                end
            end
            // Flushing the locked channel abandons its packet; resume after it
            if (lock_vld && clr_i[lock_ch]) begin
                lock_vld <= 1'b0;
                rr_ptr   <= nxt_ch(lock_ch);
            end
        end
    end
endmodule

// File: tb/tb_udma_rx_ch_arbiter.sv
// Directed bench for udma_rx_ch_arbiter with an in-order scoreboard on the output handshake.
module tb_udma_rx_ch_arbiter;
    localparam int N_CH  = 4;
    localparam int DW    = 32;
    localparam int LVL_W = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [N_CH-1:0]      in_valid_i;
    logic [N_CH*DW-1:0]   in_data_i;
    logic [N_CH*2-1:0]    in_datasize_i;
    logic [N_CH-1:0]      in_sot_i;
    logic [N_CH-1:0]      in_eot_i;
    logic [N_CH-1:0]      in_ready_o;
    logic [N_CH-1:0]      clr_i;
    logic                 out_valid_o;
    logic [DW-1:0]        out_data_o;
    logic [1:0]           out_datasize_o;
    logic [1:0]           out_ch_o;
    logic                 out_sot_o;
    logic                 out_eot_o;
    logic                 out_ready_i;
    logic [N_CH*LVL_W-1:0] lvl_o;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] data;
        logic [1:0]    size;
        logic          sot;
        logic          eot;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_got;
    beat_t mon_exp;
    int    total  = 0;
    int    passed = 0;
    int    fails  = 0;
    int    seq_ch[6] = '{1, 1, 1, 3, 0, 3};

    always #5 clk_i = ~clk_i;

    udma_rx_ch_arbiter #(
        .N_CH       (N_CH),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .LOCK_PKT   (1)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_valid_i     (in_valid_i),
        .in_data_i      (in_data_i),
        .in_datasize_i  (in_datasize_i),
        .in_sot_i       (in_sot_i),
        .in_eot_i       (in_eot_i),
        .in_ready_o     (in_ready_o),
        .clr_i          (clr_i),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_datasize_o (out_datasize_o),
        .out_ch_o       (out_ch_o),
        .out_sot_o      (out_sot_o),
        .out_eot_o      (out_eot_o),
        .out_ready_i    (out_ready_i),
        .lvl_o          (lvl_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LVL_W-1:0] lvl(input int ch);
        return lvl_o[ch*LVL_W +: LVL_W];
    endfunction

    task automatic set_beat(input int ch, input logic [DW-1:0] d, input logic [1:0] sz,
                            input logic s, input logic e);
        in_valid_i[ch]           = 1'b1;
        in_data_i[ch*DW +: DW]   = d;
        in_datasize_i[ch*2 +: 2] = sz;
        in_sot_i[ch]             = s;
        in_eot_i[ch]             = e;
    endtask

    task automatic exp_beat(input int ch, input logic [DW-1:0] d, input logic [1:0] sz,
                            input logic s, input logic e);
        exp_q.push_back({2'(ch), d, sz, s, e});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        in_valid_i = '0;
    endtask

    task automatic do_reset();
        #1 rst_i = 1'b1;
        exp_q.delete();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // Every accepted output beat must be the oldest outstanding expectation
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            mon_got = {out_ch_o, out_data_o, out_datasize_o, out_sot_o, out_eot_o};
            check("sb_expected_beat_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("sb_beat", 64'(mon_got), 64'(mon_exp));
            end
        end
    end

    initial begin
        in_valid_i = '0; in_data_i = '0; in_datasize_i = '0;
        in_sot_i = '0; in_eot_i = '0; clr_i = '0; out_ready_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_bus", 64'({out_data_o, out_datasize_o, out_ch_o, out_sot_o, out_eot_o}), 64'd0);
        check("rst_lvl", 64'(lvl_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready_o), 64'hF);

        // Single beat latency on ch2
        set_beat(2, 32'hA0, 2'b10, 1'b1, 1'b1);
        exp_beat(2, 32'hA0, 2'b10, 1'b1, 1'b1);
        tick();
        check("lat_e1_valid", 64'(out_valid_o), 64'd0);
        check("lat_e1_lvl2", 64'(lvl(2)), 64'd1);
        tick();
        check("lat_e2_valid", 64'(out_valid_o), 64'd1);
        check("lat_e2_data", 64'(out_data_o), 64'hA0);
        check("lat_e2_ch", 64'(out_ch_o), 64'd2);
        check("lat_e2_size", 64'(out_datasize_o), 64'd2);
        tick();
        check("lat_e3_valid", 64'(out_valid_o), 64'd0);

        // Round robin over two single-beat entries per channel
        do_reset();
        for (int c = 0; c < N_CH; c++) begin
            set_beat(c, 32'h100 * c + 1, 2'b00, 1'b1, 1'b1);
            exp_beat(c, 32'h100 * c + 1, 2'b00, 1'b1, 1'b1);
        end
        tick();
        for (int c = 0; c < N_CH; c++) begin
            set_beat(c, 32'h100 * c + 2, 2'b01, 1'b1, 1'b1);
            exp_beat(c, 32'h100 * c + 2, 2'b01, 1'b1, 1'b1);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            check("rr_valid", 64'(out_valid_o), 64'd1);
            check("rr_ch", 64'(out_ch_o), 64'(k % 4));
            tick();
        end
        check("rr_end_valid", 64'(out_valid_o), 64'd0);
        check("rr_end_lvl", 64'(lvl_o), 64'd0);

        // Packet lock on ch1 while ch0 and ch3 wait
        do_reset();
        out_ready_i = 1'b0;
        set_beat(1, 32'h11, 2'b10, 1'b1, 1'b0);
        set_beat(0, 32'h01, 2'b10, 1'b1, 1'b1);
        set_beat(3, 32'h31, 2'b10, 1'b1, 1'b1);
        tick();
        set_beat(1, 32'h12, 2'b10, 1'b0, 1'b0);
        set_beat(0, 32'h02, 2'b10, 1'b1, 1'b1);
        set_beat(3, 32'h32, 2'b10, 1'b1, 1'b1);
        tick();
        set_beat(1, 32'h13, 2'b10, 1'b0, 1'b1);
        tick();
        exp_beat(0, 32'h01, 2'b10, 1'b1, 1'b1);
        exp_beat(1, 32'h11, 2'b10, 1'b1, 1'b0);
        exp_beat(1, 32'h12, 2'b10, 1'b0, 1'b0);
        exp_beat(1, 32'h13, 2'b10, 1'b0, 1'b1);
        exp_beat(3, 32'h31, 2'b10, 1'b1, 1'b1);
        exp_beat(0, 32'h02, 2'b10, 1'b1, 1'b1);
        exp_beat(3, 32'h32, 2'b10, 1'b1, 1'b1);
        check("lock_stall_data", 64'(out_data_o), 64'h01);
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("lock_seq_ch", 64'(out_ch_o), 64'(seq_ch[k]));
        end
        tick();
        check("lock_end_valid", 64'(out_valid_o), 64'd0);

        // Fill ch3 behind a stalled output
        do_reset();
        out_ready_i = 1'b0;
        set_beat(0, 32'hDEAD0000, 2'b10, 1'b1, 1'b1);
        exp_beat(0, 32'hDEAD0000, 2'b10, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_beat(3, 32'h300 + k, 2'b01, 1'b1, 1'b1);
            exp_beat(3, 32'h300 + k, 2'b01, 1'b1, 1'b1);
            tick();
        end
        check("full_lvl3", 64'(lvl(3)), 64'd4);
        check("full_ready3", 64'(in_ready_o[3]), 64'd0);
        check("full_hold_data", 64'(out_data_o), 64'hDEAD0000);
        set_beat(3, 32'h3FF, 2'b01, 1'b1, 1'b1);
        tick();
        check("full_5th_lvl3", 64'(lvl(3)), 64'd4);
        check("full_hold_valid", 64'(out_valid_o), 64'd1);
        check("full_hold_ch", 64'(out_ch_o), 64'd0);
        out_ready_i = 1'b1;
        repeat (5) tick();
        check("full_drain_valid", 64'(out_valid_o), 64'd0);
        check("full_drain_lvl3", 64'(lvl(3)), 64'd0);

        // Clear a locked channel mid-packet
        do_reset();
        out_ready_i = 1'b0;
        set_beat(1, 32'h51, 2'b10, 1'b1, 1'b0);
        set_beat(2, 32'h61, 2'b10, 1'b1, 1'b1);
        tick();
        set_beat(1, 32'h52, 2'b10, 1'b0, 1'b0);
        tick();
        set_beat(1, 32'h53, 2'b10, 1'b0, 1'b0);
        tick();
        set_beat(1, 32'h54, 2'b10, 1'b0, 1'b1);
        tick();
        exp_beat(1, 32'h51, 2'b10, 1'b1, 1'b0);
        exp_beat(1, 32'h52, 2'b10, 1'b0, 1'b0);
        exp_beat(2, 32'h61, 2'b10, 1'b1, 1'b1);
        check("clr_pre_lvl1", 64'(lvl(1)), 64'd3);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        clr_i[1] = 1'b1;
        set_beat(1, 32'h5F, 2'b10, 1'b1, 1'b1);
        #1;
        check("clr_ready1", 64'(in_ready_o[1]), 64'd0);
        tick();
        clr_i = '0;
        check("clr_lvl1", 64'(lvl(1)), 64'd0);
        check("clr_keep_data", 64'(out_data_o), 64'h52);
        check("clr_keep_ch", 64'(out_ch_o), 64'd1);
        out_ready_i = 1'b1;
        tick();
        check("clr_next_ch", 64'(out_ch_o), 64'd2);
        tick();
        check("clr_end_valid", 64'(out_valid_o), 64'd0);

        // Asynchronous reset with traffic in flight
        do_reset();
        out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) set_beat(c, 32'h700 + c, 2'b00, 1'b1, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) set_beat(c, 32'h710 + c, 2'b00, 1'b1, 1'b1);
        tick();
        check("arst_pre_valid", 64'(out_valid_o), 64'd1);
        #1 rst_i = 1'b1;
        exp_q.delete();
        #1;
        check("arst_valid", 64'(out_valid_o), 64'd0);
        check("arst_lvl", 64'(lvl_o), 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        out_ready_i = 1'b1;
        set_beat(0, 32'h77, 2'b01, 1'b1, 1'b1);
        exp_beat(0, 32'h77, 2'b01, 1'b1, 1'b1);
        tick();
        check("arst_e1_valid", 64'(out_valid_o), 64'd0);
        tick();
        check("arst_e2_valid", 64'(out_valid_o), 64'd1);
        check("arst_e2_data", 64'(out_data_o), 64'h77);
        tick();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/udma_rx_ch_arbiter.md
Name: udma_rx_ch_arbiter

Overview:
- Parametrised N-channel receive-side concentrator for the uDMA core.
- Merges N_CH peripheral RX streams into one tagged stream toward the uDMA RX datapath. Each stream carries valid/data/datasize/sot/eot.
- Per-channel elastic FIFO, round-robin arbitration, optional packet lock (sot..eot), per-channel software clear, registered output stage.
- Generalises the single-channel RX handshake to multiple channels with configurable width and depth.

Parameters:
- N_CH, 4, number of input channels (>=2).
- DATA_W, 32, data width per beat.
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2).
- LOCK_PKT, 1, 1 = hold grant on a channel from a sot beat through its eot beat; 0 = beat-level round robin.
- ID_W, $clog2(N_CH), width of the channel tag (derived; minimum 1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- in_valid_i  in  N_CH  per-channel beat valid
- in_data_i  in  N_CH*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W]
- in_datasize_i  in  N_CH*2  per-channel size: 00 = byte, 01 = half, 10 = word
- in_sot_i  in  N_CH  start of transfer
- in_eot_i  in  N_CH  end of transfer
- in_ready_o  out  N_CH  per-channel accept
- clr_i  in  N_CH  per-channel synchronous flush
- out_valid_o  out  1  merged beat valid
- out_data_o  out  DATA_W  merged data
- out_datasize_o  out  2  merged datasize
- out_ch_o  out  ID_W  source channel index
- out_sot_o  out  1  forwarded sot
- out_eot_o  out  1  forwarded eot
- out_ready_i  in  1  downstream accept
- lvl_o  out  N_CH*($clog2(FIFO_DEPTH)+1)  per-channel FIFO occupancy

Behaviour:
- Reset (async, rst_i=1):
  - All FIFOs empty; lvl_o = 0.
  - out_valid_o and all out_* outputs = 0.
  - Round-robin pointer = 0; lock cleared.
  - in_ready_o = all ones once reset is released.
- Input side:
  - in_ready_o[i] = !full[i] && !clr_i[i] (combinational).
  - Push on in_valid_i[i] && in_ready_o[i]. Stored entry = {data, datasize, sot, eot}.
  - No push-bypass when full: a pop in the same cycle does not make ready high.
- Arbitration:
  - Evaluated each cycle the output register can load, i.e. !out_valid_o || out_ready_i.
  - Candidates are non-empty FIFOs. Search starts at pointer p and wraps N_CH-1 -> 0.
  - The granted channel k pops its head into the output register at the next edge. The pointer then becomes (k+1) mod N_CH.
  - No candidates: out_valid_o clears on the edge when out_ready_i=1, otherwise it holds.
- Packet lock (LOCK_PKT=1):
  - Granting a beat with sot=1, eot=0 from channel k sets lock on k.
  - While locked, only k is eligible, even if k is empty; the output then idles rather than serving other channels.
  - Lock clears on the edge that grants a beat from k with eot=1.
  - sot=eot=1 is a single-beat packet and sets no lock.
  - A sot beat arriving while already locked is passed through; the lock is kept.
- LOCK_PKT=0: sot/eot are forwarded only and do not affect arbitration.
- Output stage:
  - out_* is registered.
  - While out_valid_o && !out_ready_i, all out_* remain stable.
  - Sustained throughput: 1 beat/cycle.
  - Minimum latency: 2 cycles from input handshake edge to out_valid_o (FIFO write, then output register load).
- Clear (clr_i[i]=1):
  - FIFO i is emptied at the next edge.
  - A push on i in that cycle is refused (ready low).
  - If lock is on i, the lock is released and the pointer moves to (i+1) mod N_CH.
  - A beat already in the output register is not affected.
  - Channel i is not granted in a cycle where clr_i[i]=1.
- Reset mid-operation: everything returns to reset values immediately; no beat is retained.
- Occupancy: lvl_o[i] = entries in FIFO i, range 0..FIFO_DEPTH. Simultaneous push and pop leaves lvl_o unchanged.

Test Plan (N_CH=4, DATA_W=32, FIFO_DEPTH=4, LOCK_PKT=1):
- Reset, then push 0xA0 on ch2 at edge 1, out_ready_i=1 -> out_valid_o=1 at edge 2 with data 0xA0, out_ch_o=2, datasize copied; out_valid_o=0 at edge 3.
- Ch0..ch3 each hold 2 single-beat (sot=eot=1) entries, out_ready_i=1 -> out_ch_o sequence 0,1,2,3,0,1,2,3 with no bubbles; all lvl_o=0 at end.
- Ch1 sends a 3-beat packet (sot on beat 0, eot on beat 2) while ch0 and ch3 stay non-empty -> the three ch1 beats are contiguous on output; the next grant is ch2 if non-empty, else ch3.
- Fill ch3 with 4 beats while out_ready_i=0 -> in_ready_o[3]=0 and lvl=4; a 5th in_valid beat is not accepted; out_* holds stable; raising out_ready_i drains 4 beats in order.
- Ch1 locked mid-packet (2 of 4 beats sent), assert clr_i[1] for 1 cycle -> lvl_o[1]=0 next cycle, lock released, ch2 is served next; the beat already in the output register is delivered intact.
- Assert rst_i while 3 FIFOs are non-empty and out_valid_o=1 -> out_valid_o=0 and all lvl_o=0 immediately (asynchronously); after release, a push on ch0 emerges after 2 cycles.
